// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: shared types for the memory request arbiter.
//   state_t   : arbiter FSM states (IDLE, GNT_I, GNT_D)
//   GRANT_*   : encodings driven on the arbiter's grant output
//   grant_of  : maps an FSM state onto its grant encoding
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT_I = 2'd1,
    GNT_D = 2'd2
  } state_t;

  localparam logic [1:0] GRANT_NONE = 2'b00;
  localparam logic [1:0] GRANT_I    = 2'b01;
  localparam logic [1:0] GRANT_D    = 2'b10;

  function automatic logic [1:0] grant_of(input state_t s);
    logic [1:0] g;
    g = GRANT_NONE;
    case (s)
      GNT_I:   g = GRANT_I;
      GNT_D:   g = GRANT_D;
      default: g = GRANT_NONE;
    endcase
    return g;
  endfunction

endpackage

// File: rtl/mem_arbiter_watchdog.sv
// mem_arb_watchdog: hang-detection counter for a memory grant.
//   clk, rst  : clock, synchronous active-high reset
//   clear     : zero the count (held while no grant is active)
//   enable    : count one cycle spent waiting for memory
//   expired   : count has reached TIMEOUT_CYC (never set when TIMEOUT_CYC = 0)
// The count saturates at its all-ones value instead of wrapping.
module mem_arb_watchdog #(
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned CNT_W = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] LIMIT   = CNT_W'(TIMEOUT_CYC);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = (TIMEOUT_CYC != 0) && (cnt_q == LIMIT);

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory request port between the I-cache and the
// D-cache. All three ports use a valid/ready handshake: the master holds
// valid/addr/wr/wdata until a one-cycle ready pulse; read data is valid in
// the ready cycle.
//   clk, rst                   : clock, synchronous active-high reset
//   i_req_* / i_wr_data        : I-cache request;   i_rd_data, i_req_ready, i_err back
//   d_req_* / d_wr_data        : D-cache request;   d_rd_data, d_req_ready, d_err back
//   mem_req_* / mem_wr_data    : request to memory; mem_req_data, mem_req_ready back
//   grant                      : 01 = I owns memory, 10 = D owns memory, 00 = none
// Build option: define MEM_ARB_RR_EN for round-robin on simultaneous requests;
// otherwise D has fixed priority over I.
// Only the FSM state (plus the watchdog count and optional rr pointer) is
// registered; all outputs are a combinational mux keyed on the state.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] i_req_addr,
  input  logic              i_req_valid,
  input  logic              i_req_wr,
  input  logic [DATA_W-1:0] i_wr_data,
  output logic [DATA_W-1:0] i_rd_data,
  output logic              i_req_ready,
  output logic              i_err,
  input  logic [ADDR_W-1:0] d_req_addr,
  input  logic              d_req_valid,
  input  logic              d_req_wr,
  input  logic [DATA_W-1:0] d_wr_data,
  output logic [DATA_W-1:0] d_rd_data,
  output logic              d_req_ready,
  output logic              d_err,
  output logic [ADDR_W-1:0] mem_req_addr,
  output logic [DATA_W-1:0] mem_wr_data,
  output logic              mem_req_valid,
  output logic              mem_req_wr,
  input  logic [DATA_W-1:0] mem_req_data,
  input  logic              mem_req_ready,
  output logic [1:0]        grant
);

  state_t state_q, state_d;

  logic in_gnt;
  logic sel_d;
  logic sel_valid;
  logic done;
  logic tout;
  logic wd_expired;
  logic pick_d;

  assign in_gnt = (state_q != IDLE);
  assign sel_d  = (state_q == GNT_D);

  // Valid of the current owner; 0 in IDLE so nothing completes or times out.
  assign sel_valid = in_gnt && (sel_d ? d_req_valid : i_req_valid);

  // Ready in the expiry cycle takes precedence over the timeout.
  assign done = sel_valid && mem_req_ready;
  assign tout = sel_valid && !mem_req_ready && wd_expired;

  mem_arb_watchdog #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_watchdog (
    .clk     (clk),
    .rst     (rst),
    .clear   (!in_gnt),
    .enable  (in_gnt && !mem_req_ready),
    .expired (wd_expired)
  );

`ifdef MEM_ARB_RR_EN
  // last_i_q: the most recent completed transaction belonged to I.
  // Timeouts and withdrawals leave it unchanged.
  logic last_i_q, last_i_d;

  always_comb begin
    last_i_d = last_i_q;
    if (done) begin
      last_i_d = !sel_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_i_q <= 1'b1;
    end else begin
      last_i_q <= last_i_d;
    end
  end

  assign pick_d = last_i_q;
`else
  assign pick_d = 1'b1;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (d_req_valid && i_req_valid) begin
          state_d = pick_d ? GNT_D : GNT_I;
        end else if (d_req_valid) begin
          state_d = GNT_D;
        end else if (i_req_valid) begin
          state_d = GNT_I;
        end
      end
      GNT_I, GNT_D: begin
        // Completion, timeout and withdrawal all return through IDLE, so the
        // grant never moves to the other master mid-transaction.
        if (!sel_valid || done || tout) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    mem_req_addr  = '0;
    mem_wr_data   = '0;
    mem_req_valid = 1'b0;
    mem_req_wr    = 1'b0;
    i_rd_data     = '0;
    i_req_ready   = 1'b0;
    i_err         = 1'b0;
    d_rd_data     = '0;
    d_req_ready   = 1'b0;
    d_err         = 1'b0;
    case (state_q)
      GNT_I: begin
        mem_req_addr  = i_req_addr;
        mem_wr_data   = i_wr_data;
        mem_req_wr    = i_req_wr;
        mem_req_valid = i_req_valid && !wd_expired;
        i_rd_data     = mem_req_data;
        i_req_ready   = done;
        i_err         = tout;
      end
      GNT_D: begin
        mem_req_addr  = d_req_addr;
        mem_wr_data   = d_wr_data;
        mem_req_wr    = d_req_wr;
        mem_req_valid = d_req_valid && !wd_expired;
        d_rd_data     = mem_req_data;
        d_req_ready   = done;
        d_err         = tout;
      end
      default: ;
    endcase
  end

  assign grant = grant_of(state_q);

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed bench for mem_arbiter built with TIMEOUT_CYC = 8.
// Expected arbitration order depends on whether MEM_ARB_RR_EN is defined.
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] i_req_addr, d_req_addr, mem_req_addr;
  logic        i_req_valid, i_req_wr, d_req_valid, d_req_wr;
  logic [31:0] i_wr_data, d_wr_data, i_rd_data, d_rd_data;
  logic        i_req_ready, i_err, d_req_ready, d_err;
  logic [31:0] mem_wr_data, mem_req_data;
  logic        mem_req_valid, mem_req_wr, mem_req_ready;
  logic [1:0]  grant;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  logic [1:0] exp3 [4];

  always #5 clk = ~clk;

  mem_arbiter #(
    .ADDR_W      (32),
    .DATA_W      (32),
    .TIMEOUT_CYC (8)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .i_req_addr    (i_req_addr),
    .i_req_valid   (i_req_valid),
    .i_req_wr      (i_req_wr),
    .i_wr_data     (i_wr_data),
    .i_rd_data     (i_rd_data),
    .i_req_ready   (i_req_ready),
    .i_err         (i_err),
    .d_req_addr    (d_req_addr),
    .d_req_valid   (d_req_valid),
    .d_req_wr      (d_req_wr),
    .d_wr_data     (d_wr_data),
    .d_rd_data     (d_rd_data),
    .d_req_ready   (d_req_ready),
    .d_err         (d_err),
    .mem_req_addr  (mem_req_addr),
    .mem_wr_data   (mem_wr_data),
    .mem_req_valid (mem_req_valid),
    .mem_req_wr    (mem_req_wr),
    .mem_req_data  (mem_req_data),
    .mem_req_ready (mem_req_ready),
    .grant         (grant)
  );

  // Move to 1ns after the next rising edge; inputs are driven there.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
`ifdef MEM_ARB_RR_EN
    exp3[0] = GRANT_D; exp3[1] = GRANT_I; exp3[2] = GRANT_D; exp3[3] = GRANT_I;
`else
    exp3[0] = GRANT_D; exp3[1] = GRANT_D; exp3[2] = GRANT_D; exp3[3] = GRANT_D;
`endif
    rst = 1'b1;
    i_req_addr = '0; i_req_valid = 1'b0; i_req_wr = 1'b0; i_wr_data = '0;
    d_req_addr = '0; d_req_valid = 1'b0; d_req_wr = 1'b0; d_wr_data = '0;
    mem_req_data = '0; mem_req_ready = 1'b0;

    // Reset
    tick(); tick();
    rst = 1'b0;
    #1;
    chk("rst_grant", 32'(grant), 32'(GRANT_NONE));
    chk("rst_mem_valid", 32'(mem_req_valid), 32'd0);
    chk("rst_mem_addr", mem_req_addr, 32'd0);
    chk("rst_i_ready", 32'(i_req_ready), 32'd0);
    chk("rst_d_err", 32'(d_err), 32'd0);
    chk("rst_d_rd_data", d_rd_data, 32'd0);

    // 1: I read, memory ready 3 cycles after grant
    tick();
    i_req_valid = 1'b1; i_req_addr = 32'h40;
    #1;
    chk("t1_idle_grant", 32'(grant), 32'(GRANT_NONE));
    chk("t1_idle_mem_valid", 32'(mem_req_valid), 32'd0);
    tick(); #1;
    chk("t1_g0_grant", 32'(grant), 32'(GRANT_I));
    chk("t1_g0_addr", mem_req_addr, 32'h40);
    chk("t1_g0_mem_valid", 32'(mem_req_valid), 32'd1);
    chk("t1_g0_mem_wr", 32'(mem_req_wr), 32'd0);
    tick(); #1;
    chk("t1_g1_i_ready", 32'(i_req_ready), 32'd0);
    tick(); #1;
    chk("t1_g2_i_ready", 32'(i_req_ready), 32'd0);
    tick();
    mem_req_ready = 1'b1; mem_req_data = 32'hDEADBEEF;
    #1;
    chk("t1_i_ready", 32'(i_req_ready), 32'd1);
    chk("t1_i_rd_data", i_rd_data, 32'hDEADBEEF);
    chk("t1_d_ready", 32'(d_req_ready), 32'd0);
    chk("t1_d_rd_data", d_rd_data, 32'd0);
    chk("t1_i_err", 32'(i_err), 32'd0);
    tick();
    mem_req_ready = 1'b0; mem_req_data = '0; i_req_valid = 1'b0;
    #1;
    chk("t1_after_grant", 32'(grant), 32'(GRANT_NONE));

    // 2: D write
    tick();
    d_req_valid = 1'b1; d_req_addr = 32'h100; d_req_wr = 1'b1; d_wr_data = 32'h12345678;
    #1;
    chk("t2_idle_grant", 32'(grant), 32'(GRANT_NONE));
    tick(); #1;
    chk("t2_grant", 32'(grant), 32'(GRANT_D));
    chk("t2_mem_wr", 32'(mem_req_wr), 32'd1);
    chk("t2_mem_wdata", mem_wr_data, 32'h12345678);
    chk("t2_mem_addr", mem_req_addr, 32'h100);
    chk("t2_d_ready_wait", 32'(d_req_ready), 32'd0);
    tick();
    mem_req_ready = 1'b1; mem_req_data = 32'hAAAA5555;
    #1;
    chk("t2_d_ready", 32'(d_req_ready), 32'd1);
    chk("t2_mem_wr_ready", 32'(mem_req_wr), 32'd1);
    chk("t2_i_ready", 32'(i_req_ready), 32'd0);
    chk("t2_i_rd_data", i_rd_data, 32'd0);
    tick();
    mem_req_ready = 1'b0; mem_req_data = '0;
    d_req_valid = 1'b0; d_req_wr = 1'b0; d_wr_data = '0;
    #1;
    chk("t2_d_ready_once", 32'(d_req_ready), 32'd0);
    chk("t2_after_grant", 32'(grant), 32'(GRANT_NONE));

    // 3: both requesting for four transactions, from a fresh reset
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    i_req_valid = 1'b1; i_req_addr = 32'h200;
    d_req_valid = 1'b1; d_req_addr = 32'h300;
    #1;
    chk("t3_idle0_grant", 32'(grant), 32'(GRANT_NONE));
    for (int k = 0; k < 4; k++) begin
      tick();
      mem_req_ready = 1'b1; mem_req_data = 32'(k + 1);
      #1;
      chk($sformatf("t3_grant%0d", k), 32'(grant), 32'(exp3[k]));
      chk($sformatf("t3_i_ready%0d", k), 32'(i_req_ready), 32'(exp3[k] == GRANT_I));
      chk($sformatf("t3_d_ready%0d", k), 32'(d_req_ready), 32'(exp3[k] == GRANT_D));
      tick();
      mem_req_ready = 1'b0; mem_req_data = '0;
      #1;
      chk($sformatf("t3_idle%0d", k), 32'(grant), 32'(GRANT_NONE));
    end
    i_req_valid = 1'b0; d_req_valid = 1'b0;
    tick(); #1;
    chk("t3_end_grant", 32'(grant), 32'(GRANT_NONE));

    // 4: D timeout with TIMEOUT_CYC = 8
    d_req_valid = 1'b1; d_req_addr = 32'h500;
    tick(); #1;
    chk("t4_g0_grant", 32'(grant), 32'(GRANT_D));
    chk("t4_g0_mem_valid", 32'(mem_req_valid), 32'd1);
    for (int k = 1; k < 8; k++) begin
      tick(); #1;
      chk($sformatf("t4_g%0d_err", k), 32'(d_err), 32'd0);
      chk($sformatf("t4_g%0d_mem_valid", k), 32'(mem_req_valid), 32'd1);
    end
    tick(); #1;
    chk("t4_g8_d_err", 32'(d_err), 32'd1);
    chk("t4_g8_mem_valid", 32'(mem_req_valid), 32'd0);
    chk("t4_g8_d_ready", 32'(d_req_ready), 32'd0);
    tick();
    d_req_valid = 1'b0;
    #1;
    chk("t4_after_grant", 32'(grant), 32'(GRANT_NONE));
    chk("t4_after_err", 32'(d_err), 32'd0);

    // 4b: ready arriving in the timeout cycle completes instead
    d_req_valid = 1'b1; d_req_addr = 32'h540;
    tick(); #1;
    chk("t4b_g0_grant", 32'(grant), 32'(GRANT_D));
    for (int k = 1; k < 8; k++) begin
      tick();
    end
    tick();
    mem_req_ready = 1'b1; mem_req_data = 32'h0BADF00D;
    #1;
    chk("t4b_d_ready", 32'(d_req_ready), 32'd1);
    chk("t4b_d_err", 32'(d_err), 32'd0);
    chk("t4b_d_rd_data", d_rd_data, 32'h0BADF00D);
    tick();
    mem_req_ready = 1'b0; mem_req_data = '0; d_req_valid = 1'b0;
    #1;
    chk("t4b_after_grant", 32'(grant), 32'(GRANT_NONE));

    // 5: reset while I waits for memory
    i_req_valid = 1'b1; i_req_addr = 32'h600;
    tick(); #1;
    chk("t5_g0_grant", 32'(grant), 32'(GRANT_I));
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0; i_req_valid = 1'b0;
    mem_req_ready = 1'b1; mem_req_data = 32'h55555555;
    #1;
    chk("t5_rst_grant", 32'(grant), 32'(GRANT_NONE));
    chk("t5_rst_mem_valid", 32'(mem_req_valid), 32'd0);
    chk("t5_stale_ready", 32'(i_req_ready), 32'd0);
    tick();
    mem_req_ready = 1'b0; mem_req_data = '0;
    i_req_valid = 1'b1; i_req_addr = 32'h640;
    #1;
    chk("t5_idle_grant", 32'(grant), 32'(GRANT_NONE));
    tick(); #1;
    chk("t5_regrant", 32'(grant), 32'(GRANT_I));
    chk("t5_regrant_addr", mem_req_addr, 32'h640);
    tick();
    mem_req_ready = 1'b1; mem_req_data = 32'hCAFEF00D;
    #1;
    chk("t5_i_ready", 32'(i_req_ready), 32'd1);
    chk("t5_i_rd_data", i_rd_data, 32'hCAFEF00D);
    tick();
    mem_req_ready = 1'b0; mem_req_data = '0; i_req_valid = 1'b0;
    #1;
    chk("t5_after_grant", 32'(grant), 32'(GRANT_NONE));

    // 6: I withdraws mid-grant while D is waiting
    i_req_valid = 1'b1; i_req_addr = 32'h700;
    tick(); #1;
    chk("t6_g0_grant", 32'(grant), 32'(GRANT_I));
    tick();
    i_req_valid = 1'b0;
    d_req_valid = 1'b1; d_req_addr = 32'h800;
    #1;
    chk("t6_wd_i_ready", 32'(i_req_ready), 32'd0);
    chk("t6_wd_i_err", 32'(i_err), 32'd0);
    chk("t6_wd_mem_valid", 32'(mem_req_valid), 32'd0);
    chk("t6_wd_d_ready", 32'(d_req_ready), 32'd0);
    chk("t6_wd_grant", 32'(grant), 32'(GRANT_I));
    tick(); #1;
    chk("t6_idle_grant", 32'(grant), 32'(GRANT_NONE));
    chk("t6_idle_i_err", 32'(i_err), 32'd0);
    tick();
    mem_req_ready = 1'b1; mem_req_data = 32'h87654321;
    #1;
    chk("t6_d_grant", 32'(grant), 32'(GRANT_D));
    chk("t6_d_addr", mem_req_addr, 32'h800);
    chk("t6_d_ready", 32'(d_req_ready), 32'd1);
    chk("t6_d_rd_data", d_rd_data, 32'h87654321);
    tick();
    mem_req_ready = 1'b0; mem_req_data = '0; d_req_valid = 1'b0;
    #1;
    chk("t6_after_grant", 32'(grant), 32'(GRANT_NONE));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
